i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Single-master I2C controller, byte-array interface, up to MAX_BYTES_PER_TRANSACTION data bytes per transaction.
- Client FSMs (e.g. the ADC sampler polling the ADS-style converter at 7'h48) issue one write or read transaction per start pulse.
- Block generates START, address+R/W, data bytes with ACK handling, and STOP on open-drain SCL/SDA pins.
- Reports completion and NACK errors.

Parameters:
- MAX_BYTES_PER_TRANSACTION, 3: size of din/dout arrays and maximum byte count.
- CLK_FREQ_HZ, 125000000: system clock frequency.
- I2C_FREQ_HZ, 100000: SCL frequency. Quarter period Q = CLK_FREQ_HZ/(4*I2C_FREQ_HZ), which is 312 cycles at the defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- transaction_start  in  1  one-cycle request; sampled only in IDLE.
- rd_nwr  in  1  1 = read, 0 = write; latched on start.
- scl_pin  inout  1  open-drain SCL: driven 0 or high-Z, never driven 1.
- sda_pin  inout  1  open-drain SDA: same rule as SCL.
- slave_addr  in  7  7-bit target address; latched on start.
- din  in  8 x MAX array [0:MAX-1]  write bytes; din[0] is sent first; latched on start.
- transaction_bytes_num  in  $clog2(MAX+1)  number of data bytes; latched on start.
- dout  out  8 x MAX array [0:MAX-1]  read bytes; dout[0] is the first byte received.
- transaction_done  out  1  one-cycle pulse at end of transaction.
- error  out  1  NACK indicator for the last transaction.

Behaviour:
- Reset:
  - Both pins released to Z.
  - State = IDLE; transaction_done = 0; error = 0; all dout bytes = 0.
  - Reset mid-transaction aborts immediately. No STOP is generated.
- Pin inputs pass through a 2-FF synchronizer before any sampling.
- A quarter-phase tick counter runs only while busy.
- Each bit is 4 quarters:
  - SCL low for q0–q1, high for q2–q3.
  - SDA is updated at the start of q1.
  - SDA is sampled at the end of q2.
- States: IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, DONE.
- IDLE: SCL and SDA released. On transaction_start:
  - latch all inputs;
  - clamp byte count to MAX;
  - clear error;
  - go to START next cycle.
  - transaction_start while not IDLE is ignored.
- START: with SCL high, pull SDA low, hold Q cycles, then pull SCL low.
- ADDR:
  - Shift out {slave_addr, rd_nwr}, MSB first, 8 bits.
  - ADDR_ACK releases SDA and samples it during the 9th clock.
  - SDA high (NACK): set error, go to STOP.
  - Otherwise: if count = 0, go to STOP; else go to WR_BYTE or RD_BYTE.
- WR_BYTE / WR_ACK:
  - Send din[i] MSB first, then sample the ACK bit.
  - NACK: set error, go to STOP with no further bytes.
  - ACK: increment i; when i = count, go to STOP.
- RD_BYTE / RD_ACK:
  - Release SDA and shift 8 sampled bits, MSB first, into dout[i].
  - dout[i] is written when its 8th bit completes.
  - Master drives ACK (SDA low) for all bytes except the last, and NACK (released) for the last.
  - After the last byte, go to STOP.
- STOP: SDA low while SCL low, release SCL, wait Q, release SDA, wait Q (bus free time).
- DONE:
  - transaction_done = 1 for exactly one cycle.
  - error holds its value until the next accepted start.
  - Return to IDLE; a new start may be accepted the following cycle.
- dout entries that were not read keep their previous values. Write transactions never modify dout.
- Arbitration-loss detection is not supported (single master).

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined: after releasing SCL, the quarter counter holds until the synchronized SCL reads 1, so a slave can stretch the clock.
- Undefined: SCL high phases are purely timed and the SCL input is ignored.

Test Plan:
- Write 3 bytes: addr 7'h48, {8'h01,8'h42,8'h83}, ACKing slave model.
  - Bus shows START, 0x90, 0x01, 0x42, 0x83, each followed by ACK, then STOP.
  - transaction_done pulses once; error = 0.
- Write 1 byte 8'h00 → START, 0x90, 0x00, STOP; done pulse; dout unchanged.
- Read 2 bytes, slave returns 0x5A then 0xC3.
  - Address byte 0x91.
  - Master ACKs the first byte and NACKs the second.
  - dout[0] = 8'h5A, dout[1] = 8'hC3; error = 0.
- Address NACK (no slave at 7'h22):
  - STOP is issued right after the 9th clock.
  - done = 1 and error = 1; no data bytes appear on the bus.
- Busy and reset handling:
  - A second transaction_start pulse mid-transfer is ignored; exactly one done pulse results.
  - Reset asserted mid-byte releases both pins the next cycle; all outputs return to 0.
- Timing: with default parameters, measured SCL period = 1248 clk cycles (4 x 312), and SDA never changes while SCL is high except at START/STOP.

Source files
------------

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-master I2C controller with byte-array transactions
// Purpose: on a start pulse, sends START and address+R/W, then writes or reads
//   up to MAX_BYTES_PER_TRANSACTION data bytes with ACK handling, then STOP,
//   on open-drain SCL/SDA pins.
// Ports:
//   clk, reset             : system clock, synchronous active-high reset
//   transaction_start      : one-cycle request, accepted only when idle
//   rd_nwr, slave_addr     : direction and 7-bit target, latched on start
//   din[], transaction_bytes_num : write bytes and byte count, latched on start
//   scl_pin, sda_pin       : open-drain bus pins (driven 0 or released)
//   dout[]                 : received bytes, dout[0] first
//   transaction_done       : one-cycle completion pulse
//   error                  : NACK seen during the last transaction
// Option: define I2C_CLK_STRETCH_EN to let a slave stretch SCL high phases.
module i2c_master #(
  parameter int MAX_BYTES_PER_TRANSACTION = 3,
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int I2C_FREQ_HZ = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic transaction_start,
  input  logic rd_nwr,
  inout  wire  scl_pin,
  inout  wire  sda_pin,
  input  logic [6:0] slave_addr,
  input  logic [7:0] din [0:MAX_BYTES_PER_TRANSACTION-1],
  input  logic [$clog2(MAX_BYTES_PER_TRANSACTION+1)-1:0] transaction_bytes_num,
  output logic [7:0] dout [0:MAX_BYTES_PER_TRANSACTION-1],
  output logic transaction_done,
  output logic error
);

  localparam int MAX = MAX_BYTES_PER_TRANSACTION;
  localparam int CW = $clog2(MAX + 1);
  localparam int IW = (MAX > 1) ? $clog2(MAX) : 1;
  localparam int Q = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK,
    S_RD_BYTE, S_RD_ACK, S_STOP, S_DONE
  } state_t;

  state_t state, state_next;

  logic [QW-1:0] q_cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] byte_idx;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    addr_byte;
  logic [7:0]    din_l [0:MAX-1];
  logic [6:0]    rx_shift;
  logic          sda_low;
  logic          sda_sample;
  logic          sda_meta, sda_sync;
  logic          scl_low, busy, hold, tick, bit_end, last_byte;

  assign scl_pin = scl_low ? 1'b0 : 1'bz;
  assign sda_pin = sda_low ? 1'b0 : 1'bz;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign tick      = busy && !hold && (q_cnt == QW'(Q - 1));
  assign bit_end   = tick && (phase == 2'd3);
  assign last_byte = ((byte_idx + CW'(1)) == byte_cnt);
  assign transaction_done = (state == S_DONE);

`ifdef I2C_CLK_STRETCH_EN
  logic scl_meta, scl_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
    end else begin
      scl_meta <= scl_pin;
      scl_sync <= scl_meta;
    end
  end

  // While SCL is released but still seen low, a slave is stretching: freeze time.
  assign hold = busy && !scl_low && !scl_sync;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_next = state;
    scl_low = 1'b0;
    case (state)
      S_IDLE:     if (transaction_start) state_next = S_START;
      S_START:    if (tick) state_next = S_ADDR;
      S_ADDR:     if (bit_end && bit_cnt == 3'd7) state_next = S_ADDR_ACK;
      S_ADDR_ACK: if (bit_end) begin
        if (sda_sample || byte_cnt == '0) state_next = S_STOP;
        else if (addr_byte[0])            state_next = S_RD_BYTE;
        else                              state_next = S_WR_BYTE;
      end
      S_WR_BYTE:  if (bit_end && bit_cnt == 3'd7) state_next = S_WR_ACK;
      S_WR_ACK:   if (bit_end) state_next = (sda_sample || last_byte) ? S_STOP : S_WR_BYTE;
      S_RD_BYTE:  if (bit_end && bit_cnt == 3'd7) state_next = S_RD_ACK;
      S_RD_ACK:   if (bit_end) state_next = last_byte ? S_STOP : S_RD_BYTE;
      S_STOP:     if (bit_end) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    // Every bit slot (and the STOP slot) holds SCL low for q0-q1, released for q2-q3.
    if (state inside {S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP})
      scl_low = !phase[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      q_cnt      <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      byte_cnt   <= '0;
      addr_byte  <= '0;
      rx_shift   <= '0;
      sda_low    <= 1'b0;
      sda_sample <= 1'b1;
      sda_meta   <= 1'b1;
      sda_sync   <= 1'b1;
      error      <= 1'b0;
      for (int i = 0; i < MAX; i++) begin
        dout[i]  <= '0;
        din_l[i] <= '0;
      end
    end else begin
      state    <= state_next;
      sda_meta <= sda_pin;
      sda_sync <= sda_meta;
      if (state == S_IDLE) begin
        q_cnt    <= '0;
        phase    <= '0;
        bit_cnt  <= '0;
        byte_idx <= '0;
        if (transaction_start) begin
          addr_byte <= {slave_addr, rd_nwr};
          byte_cnt  <= (transaction_bytes_num > CW'(MAX)) ? CW'(MAX) : transaction_bytes_num;
          din_l     <= din;
          error     <= 1'b0;
          sda_low   <= 1'b1;  // START condition: SDA falls while SCL is still high
        end
      end else if (busy) begin
        if (tick) begin
          q_cnt <= '0;
          phase <= (state == S_START) ? 2'd0 : phase + 2'd1;
        end else if (!hold) begin
          q_cnt <= q_cnt + 1'b1;
        end
        // SDA only moves at the q0->q1 boundary, well inside the SCL-low half.
        if (tick && phase == 2'd0) begin
          case (state)
            S_START:   sda_low <= 1'b1;
            S_ADDR:    sda_low <= !addr_byte[~bit_cnt];
            S_WR_BYTE: sda_low <= !din_l[byte_idx[IW-1:0]][~bit_cnt];
            S_RD_ACK:  sda_low <= !last_byte;
            S_STOP:    sda_low <= 1'b1;
            default:   sda_low <= 1'b0;
          endcase
        end
        if (tick && phase == 2'd2 && state == S_STOP) sda_low <= 1'b0;
        if (tick && phase == 2'd2) sda_sample <= sda_sync;
        if (bit_end) begin
          case (state)
            S_ADDR, S_WR_BYTE: bit_cnt <= bit_cnt + 3'd1;
            S_RD_BYTE: begin
              bit_cnt  <= bit_cnt + 3'd1;
              rx_shift <= {rx_shift[5:0], sda_sample};
              if (bit_cnt == 3'd7) dout[byte_idx[IW-1:0]] <= {rx_shift, sda_sample};
            end
            S_ADDR_ACK: if (sda_sample) error <= 1'b1;
            S_WR_ACK: begin
              if (sda_sample) error <= 1'b1;
              else byte_idx <= byte_idx + CW'(1);
            end
            S_RD_ACK: byte_idx <= byte_idx + CW'(1);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - self-checking bench for i2c_master with a behavioural I2C slave
module tb_i2c_master;

  localparam int MAX = 3;
  localparam int CLK_HZ = 4000000;
  localparam int I2C_HZ = 100000;
  localparam int Q = CLK_HZ / (4 * I2C_HZ);
  localparam logic [6:0] SLV_ADDR = 7'h48;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic transaction_start = 1'b0;
  logic rd_nwr = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] din [0:MAX-1];
  logic [1:0] transaction_bytes_num = '0;
  logic [7:0] dout [0:MAX-1];
  logic transaction_done, error;
  wire scl_pin, sda_pin;

  pullup (scl_pin);
  pullup (sda_pin);

  logic slave_low = 1'b0;
  assign sda_pin = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master #(
    .MAX_BYTES_PER_TRANSACTION(MAX), .CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ)
  ) dut (
    .clk(clk), .reset(reset), .transaction_start(transaction_start), .rd_nwr(rd_nwr),
    .scl_pin(scl_pin), .sda_pin(sda_pin), .slave_addr(slave_addr), .din(din),
    .transaction_bytes_num(transaction_bytes_num), .dout(dout),
    .transaction_done(transaction_done), .error(error)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Bus monitor / slave state
  int cyc = 0, done_cnt = 0, start_cnt = 0, stop_cnt = 0, hi_changes = 0;
  int bitpos = 0, byte_no = 0, rises = 0, last_rise = 0;
  int bad_period = 0, last_period = 0, total_rises = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, in_txn = 1'b0;
  logic last_ack = 1'b1, addr_match = 1'b0, is_read = 1'b0;
  logic [7:0] shreg = '0;
  logic [8:0] bus_q [$];

  // Reference model state
  logic [7:0] wr_data [0:MAX-1];
  logic [7:0] rd_data [0:MAX-1];
  logic [7:0] exp_dout [0:MAX-1];
  logic [8:0] exp_bus [$];
  logic exp_err;

  always @(negedge clk) begin
    cyc++;
    if (transaction_done === 1'b1) done_cnt++;
    if (reset) begin
      in_txn = 1'b0; bitpos = 0; byte_no = 0; slave_low = 1'b0;
    end else begin
      if (scl_pin === 1'b1 && prev_scl === 1'b1 && sda_pin !== prev_sda) begin
        hi_changes++;
        if (sda_pin === 1'b0) begin
          start_cnt++; in_txn = 1'b1; bitpos = 0; byte_no = 0; rises = 0;
          last_ack = 1'b1; addr_match = 1'b0; is_read = 1'b0;
        end else begin
          stop_cnt++; in_txn = 1'b0; slave_low = 1'b0;
        end
      end
      if (in_txn && scl_pin === 1'b1 && prev_scl === 1'b0) begin
        if (rises > 0) begin
          last_period = cyc - last_rise;
          if (last_period != 4 * Q) bad_period++;
        end
        rises++; total_rises++; last_rise = cyc;
        if (bitpos < 8) begin
          shreg = {shreg[6:0], sda_pin};
          bitpos++;
        end else begin
          bus_q.push_back({sda_pin, shreg});
          if (byte_no == 0) begin
            addr_match = (shreg[7:1] == SLV_ADDR);
            is_read = shreg[0];
          end
          last_ack = sda_pin;
          byte_no++;
          bitpos = 9;
        end
      end
      if (in_txn && scl_pin === 1'b0 && prev_scl === 1'b1) begin
        if (bitpos == 9) bitpos = 0;
        if (bitpos == 8)
          slave_low = (byte_no == 0) ? (shreg[7:1] == SLV_ADDR) : (addr_match && !is_read);
        else if (is_read && addr_match && last_ack == 1'b0 && byte_no >= 1 && byte_no <= MAX)
          slave_low = !rd_data[byte_no-1][7-bitpos];
        else
          slave_low = 1'b0;
      end
    end
    prev_scl = scl_pin;
    prev_sda = sda_pin;
  end

  task automatic model_txn(input logic [6:0] a, input logic rw, input int n_req);
    int n;
    n = (n_req > MAX) ? MAX : n_req;
    exp_bus.delete();
    exp_err = (a != SLV_ADDR);
    exp_bus.push_back({exp_err, a, rw});
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        if (rw) begin
          exp_bus.push_back({((i == n - 1) ? 1'b1 : 1'b0), rd_data[i]});
          exp_dout[i] = rd_data[i];
        end else begin
          exp_bus.push_back({1'b0, wr_data[i]});
        end
      end
    end
  endtask

  task automatic do_txn(input logic [6:0] a, input logic rw, input int n,
                        input bit extra_start, output bit timed_out);
    bus_q.delete();
    start_cnt = 0; stop_cnt = 0; hi_changes = 0; done_cnt = 0;
    slave_addr = a; rd_nwr = rw; transaction_bytes_num = n[1:0];
    for (int i = 0; i < MAX; i++) din[i] = wr_data[i];
    transaction_start = 1'b1;
    @(posedge clk); #1;
    transaction_start = 1'b0;
    if (extra_start) begin
      repeat (300) @(posedge clk);
      #1;
      slave_addr = 7'h11; rd_nwr = ~rw; transaction_start = 1'b1;
      @(posedge clk); #1;
      transaction_start = 1'b0;
    end
    timed_out = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done_cnt != 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (scl_pin !== 1'b1 || sda_pin !== 1'b1) begin
      n_fail++; $display("FAIL reset_pins: scl %b sda %b, expected 1 1", scl_pin, sda_pin);
    end
    n_checks++;
    if (transaction_done !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: done %b error %b, expected 0 0", transaction_done, error);
    end
    for (int i = 0; i < MAX; i++) begin
      exp_dout[i] = 8'h00;
      n_checks++;
      if (dout[i] !== 8'h00) begin
        n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 00", i, dout[i]);
      end
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    bit to;
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        wr_data[0] = 8'h01; wr_data[1] = 8'h42; wr_data[2] = 8'h83; n = 3;
      end else begin
        wr_data[0] = 8'h00; wr_data[1] = 8'hFF; wr_data[2] = 8'hFF; n = 1;
      end
      model_txn(SLV_ADDR, 1'b0, n);
      do_txn(SLV_ADDR, 1'b0, n, 1'b0, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL write_timeout: no done pulse within bound (case %0d)", k); end
      n_checks++;
      if (bus_q.size() != exp_bus.size()) begin
        n_fail++; $display("FAIL write_bus_len: got %0d bytes expected %0d", bus_q.size(), exp_bus.size());
      end
      for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
        n_checks++;
        if (bus_q[i] !== exp_bus[i]) begin
          n_fail++; $display("FAIL write_bus[%0d]: got {ack,byte} %h expected %h", i, bus_q[i], exp_bus[i]);
        end
      end
      n_checks++;
      if (done_cnt != 1 || error !== exp_err) begin
        n_fail++; $display("FAIL write_status: done pulses %0d error %b, expected 1 %b", done_cnt, error, exp_err);
      end
      n_checks++;
      if (start_cnt != 1 || stop_cnt != 1 || hi_changes != 2) begin
        n_fail++; $display("FAIL write_framing: starts %0d stops %0d sda-edges-scl-high %0d, expected 1 1 2",
                           start_cnt, stop_cnt, hi_changes);
      end
      for (int i = 0; i < MAX; i++) begin
        n_checks++;
        if (dout[i] !== exp_dout[i]) begin
          n_fail++; $display("FAIL write_dout[%0d]: got %h expected %h", i, dout[i], exp_dout[i]);
        end
      end
    end
  endtask

  task automatic test_read();
    bit to;
    rd_data[0] = 8'h5A; rd_data[1] = 8'hC3; rd_data[2] = 8'h77;
    model_txn(SLV_ADDR, 1'b1, 2);
    do_txn(SLV_ADDR, 1'b1, 2, 1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL read_timeout: no done pulse within bound"); end
    n_checks++;
    if (bus_q.size() != exp_bus.size()) begin
      n_fail++; $display("FAIL read_bus_len: got %0d bytes expected %0d", bus_q.size(), exp_bus.size());
    end
    for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
      n_checks++;
      if (bus_q[i] !== exp_bus[i]) begin
        n_fail++; $display("FAIL read_bus[%0d]: got {ack,byte} %h expected %h", i, bus_q[i], exp_bus[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1 || error !== 1'b0 || stop_cnt != 1 || hi_changes != 2) begin
      n_fail++; $display("FAIL read_status: done %0d error %b stops %0d sda-edges-scl-high %0d, expected 1 0 1 2",
                         done_cnt, error, stop_cnt, hi_changes);
    end
    for (int i = 0; i < MAX; i++) begin
      n_checks++;
      if (dout[i] !== exp_dout[i]) begin
        n_fail++; $display("FAIL read_dout[%0d]: got %h expected %h", i, dout[i], exp_dout[i]);
      end
    end
  endtask

  task automatic test_addr_nack();
    bit to;
    wr_data[0] = 8'hAA; wr_data[1] = 8'h55;
    model_txn(7'h22, 1'b0, 2);
    do_txn(7'h22, 1'b0, 2, 1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL nack_timeout: no done pulse within bound"); end
    n_checks++;
    if (bus_q.size() != 1 || bus_q[0] !== exp_bus[0]) begin
      n_fail++; $display("FAIL nack_bus: got %0d bytes first %h, expected 1 byte %h",
                         bus_q.size(), (bus_q.size() > 0) ? bus_q[0] : 9'h000, exp_bus[0]);
    end
    n_checks++;
    if (done_cnt != 1 || error !== 1'b1 || stop_cnt != 1) begin
      n_fail++; $display("FAIL nack_status: done %0d error %b stops %0d, expected 1 1 1", done_cnt, error, stop_cnt);
    end
  endtask

  task automatic test_busy();
    bit to;
    wr_data[0] = 8'h3C; wr_data[1] = 8'hE1;
    model_txn(SLV_ADDR, 1'b0, 2);
    do_txn(SLV_ADDR, 1'b0, 2, 1'b1, to);
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (to) begin n_fail++; $display("FAIL busy_timeout: no done pulse within bound"); end
    n_checks++;
    if (done_cnt != 1 || start_cnt != 1) begin
      n_fail++; $display("FAIL busy_single: done pulses %0d starts %0d, expected 1 1", done_cnt, start_cnt);
    end
    n_checks++;
    if (bus_q.size() != exp_bus.size() || bus_q[0] !== exp_bus[0] || error !== 1'b0) begin
      n_fail++; $display("FAIL busy_bus: %0d bytes addr %h error %b, expected %0d bytes addr %h error 0",
                         bus_q.size(), (bus_q.size() > 0) ? bus_q[0] : 9'h000, error, exp_bus.size(), exp_bus[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    wr_data[0] = 8'h00; wr_data[1] = 8'h00; wr_data[2] = 8'h00;
    slave_addr = SLV_ADDR; rd_nwr = 1'b0; transaction_bytes_num = 2'd3;
    for (int i = 0; i < MAX; i++) din[i] = wr_data[i];
    transaction_start = 1'b1;
    @(posedge clk); #1;
    transaction_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (byte_no == 1 && bitpos == 3) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL rstmid_reach: data byte never started on the bus"); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (scl_pin !== 1'b1 || sda_pin !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pins: scl %b sda %b, expected 1 1", scl_pin, sda_pin);
    end
    n_checks++;
    if (transaction_done !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: done %b error %b, expected 0 0", transaction_done, error);
    end
    for (int i = 0; i < MAX; i++) begin
      exp_dout[i] = 8'h00;
      n_checks++;
      if (dout[i] !== 8'h00) begin
        n_fail++; $display("FAIL rstmid_dout[%0d]: got %h expected 00", i, dout[i]);
      end
    end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit to;
    logic [6:0] a;
    logic rw;
    int n;
    for (int k = 0; k < 8; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLV_ADDR;
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(0, MAX);
      for (int i = 0; i < MAX; i++) begin
        wr_data[i] = 8'($urandom);
        rd_data[i] = 8'($urandom);
      end
      model_txn(a, rw, n);
      do_txn(a, rw, n, 1'b0, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL rand%0d_timeout: no done pulse within bound", k); end
      n_checks++;
      if (bus_q.size() != exp_bus.size()) begin
        n_fail++; $display("FAIL rand%0d_bus_len: got %0d bytes expected %0d", k, bus_q.size(), exp_bus.size());
      end
      for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
        n_checks++;
        if (bus_q[i] !== exp_bus[i]) begin
          n_fail++; $display("FAIL rand%0d_bus[%0d]: got %h expected %h", k, i, bus_q[i], exp_bus[i]);
        end
      end
      n_checks++;
      if (done_cnt != 1 || error !== exp_err || stop_cnt != 1 || hi_changes != 2) begin
        n_fail++; $display("FAIL rand%0d_status: done %0d error %b stops %0d sda-edges-scl-high %0d, expected 1 %b 1 2",
                           k, done_cnt, error, stop_cnt, hi_changes, exp_err);
      end
      for (int i = 0; i < MAX; i++) begin
        n_checks++;
        if (dout[i] !== exp_dout[i]) begin
          n_fail++; $display("FAIL rand%0d_dout[%0d]: got %h expected %h", k, i, dout[i], exp_dout[i]);
        end
      end
    end
  endtask

  task automatic test_timing();
    n_checks++;
    if (total_rises < 100 || last_period != 4 * Q) begin
      n_fail++; $display("FAIL timing_period: last SCL period %0d over %0d edges, expected %0d",
                         last_period, total_rises, 4 * Q);
    end
    n_checks++;
    if (bad_period != 0) begin
      n_fail++; $display("FAIL timing_jitter: %0d SCL periods differ from %0d", bad_period, 4 * Q);
    end
  endtask

  initial begin
    for (int i = 0; i < MAX; i++) begin
      din[i] = 8'h00; wr_data[i] = 8'h00; rd_data[i] = 8'h00; exp_dout[i] = 8'h00;
    end
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_busy();
    test_reset_mid();
    test_random();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
